regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port (WE3/AD3/WD3) between the in-order pipeline writeback and a multi-cycle execution unit (divider/memory return) that completes late. Holds a per-register busy scoreboard for outstanding multi-cycle destinations and reports source-operand hazards to the stall logic. Write-port outputs are registered; the block sits between writeback and `regfile`.

## Interface
- STARVE_LIMIT, 4: cycles a pending multi-cycle write may lose arbitration before it is forced; legal 1..255
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- p_valid  in  1  pipeline writeback request
- p_rd  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle (combinational)
- m_valid  in  1  multi-cycle unit completion request
- m_rd  in  5  multi-cycle destination register
- m_data  in  32  multi-cycle write data
- m_ready  out  1  multi-cycle request accepted this cycle (combinational)
- issue_valid  in  1  multi-cycle op is being issued
- issue_rd  in  5  destination of issued op
- issue_ready  out  1  issue permitted (destination not busy)
- rs1, rs2  in  5 each  source registers of the instruction in decode
- hazard  out  1  decode must stall: a source register has an outstanding write
- WE3  out  1  regfile write enable (registered)
- AD3  out  5  regfile write address (registered)
- WD3  out  32  regfile write data (registered)

## Operation
- State: busy[31:1] scoreboard, wait_cnt (8 bits), output register {WE3, AD3, WD3, from_m}.
- Arbitration per cycle, evaluated combinationally:
  - force = m_valid && wait_cnt == STARVE_LIMIT.
  - force: m_ready=1, p_ready=0.
  - else: p_ready=1; m_ready = !p_valid.
- Accepted request (valid && ready) loads the output register at the edge: WE3 = (rd != 0), AD3 = rd, WD3 = data, from_m = accepted-from-M. No acceptance: WE3=0, AD3/WD3 hold.
- x0 writes are accepted and handshaken normally but never assert WE3.
- wait_cnt: cleared when M is accepted or m_valid=0; incremented when m_valid && !m_ready; saturates at STARVE_LIMIT.
- Scoreboard:
  - Set busy[issue_rd] at the edge when issue_valid && issue_ready && issue_rd != 0.
  - issue_ready = (issue_rd == 0) || !busy[issue_rd] (WAW stall).
  - Clear busy[AD3] at the edge ending a cycle where WE3 && from_m, i.e. the edge at which the regfile captures the write.
  - Set and clear of the same register on the same edge: set wins.
- hazard = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]) || (WE3 && AD3 != 0 && (AD3 == rs1 || AD3 == rs2)). The last term covers the write in flight, because regfile reads are synchronous.
- m_valid with m_rd not busy is legal: write performed, clear is a no-op.

## Timing
- Reset values: WE3=0, AD3=0, WD3=0, from_m=0, busy all 0, wait_cnt=0. Outputs follow: p_ready=1, m_ready=!p_valid, issue_ready=1, hazard=0.
- Reset asserted mid-operation: all state clears immediately. Pending scoreboard entries are lost; the upstream unit is also reset.
- Latency: a request accepted at edge N drives WE3 during cycle N+1 and is written into the regfile at edge N+1. A busy bit clears at edge N+1.
- Handshake: requester holds valid/rd/data stable until ready. p_ready/m_ready depend only on the current-cycle valids and wait_cnt, with no combinational path from WE3.
- Throughput: one write per cycle. With continuous p_valid and m_valid, M is accepted once every STARVE_LIMIT+1 cycles.

## Test plan
- Reset, then p_valid=1, p_rd=5, p_data=0xDEADBEEF for one cycle -> p_ready=1; next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; following cycle WE3=0.
- p_rd=0, p_data=0x1234 -> p_ready=1; WE3 stays 0 next cycle; hazard stays 0 throughout.
- issue rd=7 -> busy[7] set; rs1=7 -> hazard=1; issue_rd=7 again -> issue_ready=0; m_valid, m_rd=7, m_data=0x55 with p_valid=0 -> accepted; next cycle WE3=1/AD3=7 with hazard=1; cycle after, hazard=0 and issue_ready=1.
- STARVE_LIMIT=4, p_valid and m_valid held high -> m_ready low for 4 cycles, high on the 5th while p_ready=0; wait_cnt returns to 0; pattern repeats every 5 cycles.
- Issue to rd=9 on the same edge that the M write to rd=9 commits -> busy[9]=1 afterwards (set wins).
- Assert rst while busy[3]=1 and WE3=1 -> WE3, AD3, WD3 and busy clear without waiting for a clock edge; hazard=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of signals between writeback, the multi-cycle unit, decode and the regfile write port.
// The slave modport is the arbiter's view. The master modport is the surrounding pipeline's view.
interface regfile_wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_ready;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;

  modport slave (
    input  p_valid, p_rd, p_data, m_valid, m_rd, m_data,
           issue_valid, issue_rd, rs1, rs2,
    output p_ready, m_ready, issue_ready, hazard, WE3, AD3, WD3
  );

  modport master (
    output p_valid, p_rd, p_data, m_valid, m_rd, m_data,
           issue_valid, issue_rd, rs1, rs2,
    input  p_ready, m_ready, issue_ready, hazard, WE3, AD3, WD3
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback and a late multi-cycle unit,
// and keeps a busy scoreboard of outstanding multi-cycle destinations for hazard detection.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [31:1] busy_q, busy_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        we_q, we_d;
  logic [4:0]  ad_q, ad_d;
  logic [31:0] wd_q, wd_d;
  logic        fromM_q, fromM_d;

  logic        forceM;
  logic        pAccept;
  logic        mAccept;
  logic [31:0] busyVec;
  logic [31:0] busyNext;

  assign busyVec = {busy_q, 1'b0};
  assign forceM  = bus.m_valid && (waitCnt_q == LIMIT);
  assign pAccept = bus.p_valid && !forceM;
  assign mAccept = bus.m_valid && (forceM || !bus.p_valid);

  assign bus.p_ready     = !forceM;
  assign bus.m_ready     = forceM || !bus.p_valid;
  assign bus.issue_ready = (bus.issue_rd == 5'd0) || !busyVec[bus.issue_rd];

  // The in-flight term matters because the regfile reads synchronously and misses this write.
  assign bus.hazard = ((bus.rs1 != 5'd0) && busyVec[bus.rs1]) ||
                      ((bus.rs2 != 5'd0) && busyVec[bus.rs2]) ||
                      (we_q && (ad_q != 5'd0) && ((ad_q == bus.rs1) || (ad_q == bus.rs2)));

  assign bus.WE3 = we_q;
  assign bus.AD3 = ad_q;
  assign bus.WD3 = wd_q;

  always_comb begin
    we_d    = 1'b0;
    ad_d    = ad_q;
    wd_d    = wd_q;
    fromM_d = 1'b0;
    if (mAccept) begin
      we_d    = (bus.m_rd != 5'd0);
      ad_d    = bus.m_rd;
      wd_d    = bus.m_data;
      fromM_d = 1'b1;
    end else if (pAccept) begin
      we_d    = (bus.p_rd != 5'd0);
      ad_d    = bus.p_rd;
      wd_d    = bus.p_data;
    end
  end

  // Clear is applied before set so an issue on the commit edge keeps the register busy.
  always_comb begin
    busyNext = busyVec;
    if (we_q && fromM_q) begin
      busyNext[ad_q] = 1'b0;
    end
    if (bus.issue_valid && bus.issue_ready && (bus.issue_rd != 5'd0)) begin
      busyNext[bus.issue_rd] = 1'b1;
    end
    busy_d = busyNext[31:1];
  end

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!bus.m_valid || mAccept) begin
      waitCnt_d = 8'd0;
    end else if (waitCnt_q != LIMIT) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      waitCnt_q <= 8'd0;
      we_q      <= 1'b0;
      ad_q      <= 5'd0;
      wd_q      <= 32'd0;
      fromM_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      waitCnt_q <= waitCnt_d;
      we_q      <= we_d;
      ad_q      <= ad_d;
      wd_q      <= wd_d;
      fromM_q   <= fromM_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 1'b0;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          fromM;
  } write_t;

  // Model: the set of registers owed a multi-cycle result, how many cycles M has been
  // passed over in a row, and the write currently presented to the regfile.
  bit     owed [32];
  int     lossStreak;
  write_t inFlight;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit srcBlocked(input logic [4:0] r);
    return (r != 5'd0) && (owed[r] || (inFlight.we && inFlight.rd == r));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (owed[i]) owed[i] = 1'b0;
      lossStreak = 0;
      inFlight   = '{1'b0, 5'd0, 32'd0, 1'b0};
    end else begin
      bit mStarved;
      bit mWins;
      bit pWins;
      bit issueOk;
      mStarved = bus.m_valid && (lossStreak == LIMIT);
      mWins    = bus.m_valid && (mStarved || !bus.p_valid);
      pWins    = bus.p_valid && !mStarved;
      issueOk  = (bus.issue_rd == 5'd0) || !owed[bus.issue_rd];
      if (inFlight.we && inFlight.fromM) owed[inFlight.rd] = 1'b0;
      if (bus.issue_valid && issueOk && bus.issue_rd != 5'd0) owed[bus.issue_rd] = 1'b1;
      if (mWins)
        inFlight = '{(bus.m_rd != 5'd0), bus.m_rd, bus.m_data, 1'b1};
      else if (pWins)
        inFlight = '{(bus.p_rd != 5'd0), bus.p_rd, bus.p_data, 1'b0};
      else begin
        inFlight.we    = 1'b0;
        inFlight.fromM = 1'b0;
      end
      if (!bus.m_valid || mWins) lossStreak = 0;
      else if (lossStreak < LIMIT) lossStreak = lossStreak + 1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      bit mStarved;
      mStarved = bus.m_valid && (lossStreak == LIMIT);
      checkOutput("p_ready", bus.p_ready, !mStarved);
      checkOutput("m_ready", bus.m_ready, mStarved || !bus.p_valid);
      checkOutput("issue_ready", bus.issue_ready, (bus.issue_rd == 5'd0) || !owed[bus.issue_rd]);
      checkOutput("hazard", bus.hazard, srcBlocked(bus.rs1) || srcBlocked(bus.rs2));
      checkOutput("WE3", bus.WE3, inFlight.we);
      checkOutput("AD3", bus.AD3, inFlight.rd);
      checkOutput("WD3", bus.WD3, inFlight.data);
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit keepP;
    bit keepM;
    rst             = 1'b1;
    bus.p_valid     = 1'b0; bus.p_rd = 5'd0; bus.p_data = 32'd0;
    bus.m_valid     = 1'b0; bus.m_rd = 5'd0; bus.m_data = 32'd0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.rs1         = 5'd0; bus.rs2 = 5'd0;

    @(negedge clk);
    checkOutput("reset WE3", bus.WE3, 32'd0);
    checkOutput("reset AD3", bus.AD3, 32'd0);
    checkOutput("reset WD3", bus.WD3, 32'd0);
    checkOutput("reset p_ready", bus.p_ready, 32'd1);
    checkOutput("reset m_ready", bus.m_ready, 32'd1);
    checkOutput("reset issue_ready", bus.issue_ready, 32'd1);
    checkOutput("reset hazard", bus.hazard, 32'd0);
    rst     = 1'b0;
    checkEn = 1'b1;

    // Plain pipeline write.
    applyStimulus();
    bus.p_valid = 1'b1; bus.p_rd = 5'd5; bus.p_data = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("p write ready", bus.p_ready, 32'd1);
    applyStimulus();
    bus.p_valid = 1'b0;
    @(negedge clk);
    checkOutput("p write WE3", bus.WE3, 32'd1);
    checkOutput("p write AD3", bus.AD3, 32'd5);
    checkOutput("p write WD3", bus.WD3, 32'hDEADBEEF);
    applyStimulus();
    @(negedge clk);
    checkOutput("p write WE3 drop", bus.WE3, 32'd0);

    // Write to x0 is handshaken but suppressed.
    applyStimulus();
    bus.p_valid = 1'b1; bus.p_rd = 5'd0; bus.p_data = 32'h1234;
    @(negedge clk);
    checkOutput("x0 ready", bus.p_ready, 32'd1);
    checkOutput("x0 hazard", bus.hazard, 32'd0);
    applyStimulus();
    bus.p_valid = 1'b0;
    @(negedge clk);
    checkOutput("x0 WE3", bus.WE3, 32'd0);
    checkOutput("x0 hazard after", bus.hazard, 32'd0);

    // Scoreboard lifecycle of rd=7.
    applyStimulus();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    @(negedge clk);
    checkOutput("issue7 ready", bus.issue_ready, 32'd1);
    applyStimulus();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd7;
    @(negedge clk);
    checkOutput("rs1=7 hazard", bus.hazard, 32'd1);
    checkOutput("issue7 WAW", bus.issue_ready, 32'd0);
    applyStimulus();
    bus.m_valid = 1'b1; bus.m_rd = 5'd7; bus.m_data = 32'h55;
    @(negedge clk);
    checkOutput("m7 ready", bus.m_ready, 32'd1);
    applyStimulus();
    bus.m_valid = 1'b0;
    @(negedge clk);
    checkOutput("m7 WE3", bus.WE3, 32'd1);
    checkOutput("m7 AD3", bus.AD3, 32'd7);
    checkOutput("m7 hazard inflight", bus.hazard, 32'd1);
    applyStimulus();
    @(negedge clk);
    checkOutput("m7 hazard cleared", bus.hazard, 32'd0);
    checkOutput("m7 issue_ready", bus.issue_ready, 32'd1);
    bus.rs1 = 5'd0;

    // Issue on the same edge that an M write to rd=9 commits: set wins.
    applyStimulus();
    bus.m_valid = 1'b1; bus.m_rd = 5'd9; bus.m_data = 32'h99;
    @(negedge clk);
    checkOutput("m9 ready", bus.m_ready, 32'd1);
    applyStimulus();
    bus.m_valid = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    @(negedge clk);
    checkOutput("m9 WE3", bus.WE3, 32'd1);
    checkOutput("m9 AD3", bus.AD3, 32'd9);
    applyStimulus();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd9;
    @(negedge clk);
    checkOutput("set wins WE3", bus.WE3, 32'd0);
    checkOutput("set wins hazard", bus.hazard, 32'd1);
    checkOutput("set wins issue_ready", bus.issue_ready, 32'd0);
    bus.rs1 = 5'd0;

    // Starvation: M wins one cycle in every LIMIT+1.
    applyStimulus();
    bus.p_valid = 1'b1; bus.p_rd = 5'd10; bus.p_data = 32'hA0A0;
    bus.m_valid = 1'b1; bus.m_rd = 5'd11; bus.m_data = 32'hB1B1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("starve m_ready", bus.m_ready, 32'((k % 5) == 4));
      checkOutput("starve p_ready", bus.p_ready, 32'((k % 5) != 4));
      applyStimulus();
    end
    bus.p_valid = 1'b0; bus.m_valid = 1'b0;

    // Asynchronous reset with a write in flight and a busy entry.
    applyStimulus();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    applyStimulus();
    bus.issue_valid = 1'b0; bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 32'hABCD;
    applyStimulus();
    bus.p_valid = 1'b0; bus.rs1 = 5'd3;
    #1;
    checkOutput("pre-reset WE3", bus.WE3, 32'd1);
    checkOutput("pre-reset hazard", bus.hazard, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async WE3", bus.WE3, 32'd0);
    checkOutput("async AD3", bus.AD3, 32'd0);
    checkOutput("async WD3", bus.WD3, 32'd0);
    checkOutput("async hazard", bus.hazard, 32'd0);
    checkOutput("async issue_ready", bus.issue_ready, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.rs1 = 5'd0;

    // Randomized traffic; requesters hold their request until it is taken.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      keepP = bus.p_valid && !bus.p_ready;
      keepM = bus.m_valid && !bus.m_ready;
      applyStimulus();
      if (!keepP) begin
        bus.p_valid = ($urandom_range(0, 99) < 60);
        bus.p_rd    = 5'($urandom_range(0, 7));
        bus.p_data  = $urandom;
      end
      if (!keepM) begin
        bus.m_valid = ($urandom_range(0, 99) < 45);
        bus.m_rd    = 5'($urandom_range(0, 7));
        bus.m_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 99) < 30);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
    end
    @(negedge clk);
    checkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
